// File: rtl/sfifo_rd_stream_if.sv
// Bundle of the sfifo read port and the outgoing valid/ready stream.
// Latency: none, wires only.
// Backpressure: carries m_ready upstream to the drain stage; fifo_r_en is the credit-gated read.
interface sfifo_rd_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_r_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [CNT_W-1:0]  word_cnt;

    // Drain stage side: reads the FIFO, drives the stream.
    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_r_en, m_valid, m_data, word_cnt
    );

    // Environment side: the sfifo plus the stream consumer.
    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_r_en, m_valid, m_data, word_cnt
    );
endinterface

// File: rtl/sfifo_rd_stream.sv
// Drains sfifo (r_en/dout/empty, RD_LAT read latency) into a valid/ready stream via a skid ring.
// Latency: fifo_r_en in cycle N -> m_valid in cycle N+RD_LAT+1; one word per cycle sustained.
// Backpressure: reads are issued only on credit (occ + in-flight < DEPTH), so stalls never drop data.
module sfifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    sfifo_rd_stream_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = $clog2(DEPTH + RD_LAT + 1);

    logic [RD_LAT-1:0] inflight;
    logic [RD_LAT-1:0] inflight_nxt;
    logic [DATA_W-1:0] buffer [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [SUM_W-1:0]  infl;
    logic [SUM_W-1:0]  credit_used;
    logic [CNT_W-1:0]  word_cnt;
    logic              r_en;
    logic              push;
    logic              pop;
    logic              valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap so DEPTH need not be a power of two.
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Count reads still travelling through the FIFO read pipeline.
    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl = infl + SUM_W'(inflight[i]);
        end
    end

    // Credit = buffered words plus words already requested; never exceed the ring size.
    assign credit_used = SUM_W'(occ) + infl;
    assign r_en        = !rst && !bus.fifo_empty && (credit_used < SUM_W'(DEPTH));

    // The word requested RD_LAT edges ago is on fifo_dout at this edge.
    assign push  = inflight[RD_LAT-1];
    assign valid = (occ != '0);
    assign pop   = valid && bus.m_ready;

    // Next in-flight vector: age every request by one edge and insert today's read.
    always_comb begin
        inflight_nxt    = inflight << 1;
        inflight_nxt[0] = r_en;
    end

    // Control state: in-flight tracker, ring pointers, occupancy and delivered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            word_cnt <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                word_cnt <= word_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Data storage; returned words arriving during reset are discarded with the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            buffer[wr_ptr] <= bus.fifo_dout;
        end
    end

    assign bus.fifo_r_en = r_en;
    assign bus.m_valid   = valid;
    assign bus.m_data    = valid ? buffer[rd_ptr] : '0;
    assign bus.word_cnt  = word_cnt;

    // A push into a full ring means the credit scheme is broken.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ == OCC_W'(DEPTH))));

    // Buffered plus requested words must always fit in the ring.
    assert property (@(posedge clk) disable iff (rst)
        (credit_used <= SUM_W'(DEPTH)));
endmodule
